// File: rtl/fmin_reduce.sv
// Registered IEEE-754 single-precision minimum with streaming group reduction.
// Each accepted beat yields a pair minimum; pair minimums are folded until the group's last beat.
module fmin_reduce #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Fmin_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        first,
    input  logic        last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mindata_out,
    output logic        nan_flag
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction

    // Sign-magnitude ordering: one NaN is ignored, two NaNs collapse to the canonical NaN.
    function automatic logic [31:0] fp_min(input logic [31:0] a, input logic [31:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        if (a_nan && b_nan)      return CANON_NAN;
        else if (a_nan)          return b;
        else if (b_nan)          return a;
        else if (a == b)         return a;
        else if (a[31] != b[31]) return a[31] ? a : b;
        else if (!a[31])         return (a[30:0] < b[30:0]) ? a : b;
        else                     return (a[30:0] > b[30:0]) ? a : b;
    endfunction

    state_t      state_q;
    logic        s1_valid_q;
    logic [31:0] s1_pmin_q;
    logic        s1_pnan_q;
    logic        s1_first_q;
    logic        s1_last_q;
    logic [31:0] acc_q;
    logic        sticky_q;
    logic        out_valid_q;
    logic [31:0] mindata_q;
    logic        nan_q;

    logic        stall;
    logic        accept;
    logic        group_start;
    logic [31:0] fold_d;
    logic        sticky_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = Fmin_en && !stall;
    assign accept   = in_valid && in_ready;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        group_start = s1_first_q || (state_q == IDLE);
        fold_d      = group_start ? s1_pmin_q : fp_min(acc_q, s1_pmin_q);
        sticky_d    = s1_pnan_q || (!group_start && sticky_q);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_valid_q  <= 1'b0;
            s1_pmin_q   <= '0;
            s1_pnan_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mindata_q   <= '0;
            nan_q       <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_pmin_q  <= fp_min(read_data1, read_data2);
                s1_pnan_q  <= is_nan(read_data1) || is_nan(read_data2);
                s1_first_q <= first;
                s1_last_q  <= last;
            end

            // Not stalled means the output slot is empty or being consumed this edge.
            out_valid_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    mindata_q <= fold_d;
                    nan_q     <= sticky_d;
                    state_q   <= IDLE;
                end else begin
                    acc_q     <= fold_d;
                    sticky_q  <= sticky_d;
                    state_q   <= ACCUM;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign mindata_out = mindata_q;
    assign nan_flag    = nan_q;

endmodule

// File: tb/tb_fmin_reduce.sv
// Directed self-checking bench for fmin_reduce: pair ordering, group folding,
// NaN handling, backpressure, enable gating and synchronous reset.
module tb_fmin_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        Fmin_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        first;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mindata_out;
    logic        nan_flag;

    int n_checks = 0;
    int n_pass   = 0;

    fmin_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .Fmin_en    (Fmin_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .first      (first),
        .last       (last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mindata_out(mindata_out),
        .nan_flag   (nan_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns one step after the edge that accepted it.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                             input logic f, input logic l);
        logic done;
        done       = 1'b0;
        read_data1 = a;
        read_data2 = b;
        first      = f;
        last       = l;
        in_valid   = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp_d, input logic exp_n);
        int waited;
        waited = 0;
        while (!out_valid && waited < 10) begin
            step();
            waited++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, mindata_out, exp_d);
        check({tag, "_nan"}, {31'd0, nan_flag}, {31'd0, exp_n});
        step();
    endtask

    initial begin
        rst        = 1'b1;
        Fmin_en    = 1'b1;
        in_valid   = 1'b0;
        read_data1 = '0;
        read_data2 = '0;
        first      = 1'b0;
        last       = 1'b0;
        out_ready  = 1'b1;
        repeat (2) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", mindata_out, 32'h0);
        check("rst_nan", {31'd0, nan_flag}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-beat group with exact latency and a one-cycle valid pulse.
        read_data1 = 32'h4020_0000;
        read_data2 = 32'h4160_0000;
        first      = 1'b1;
        last       = 1'b1;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", mindata_out, 32'h4020_0000);
        check("t1_nan", {31'd0, nan_flag}, 32'd0);
        step();
        check("t1_pulse_end", {31'd0, out_valid}, 32'd0);

        // Three-beat group: no output until the last beat, result is -130.
        send_beat(32'h4268_0000, 32'h42F0_0000, 1'b1, 1'b0);
        check("t2_mid1_valid", {31'd0, out_valid}, 32'd0);
        send_beat(32'hC143_3333, 32'h4093_3333, 1'b0, 1'b0);
        check("t2_mid2_valid", {31'd0, out_valid}, 32'd0);
        send_beat(32'h4200_0000, 32'hC302_0000, 1'b0, 1'b1);
        check("t2_lat1_valid", {31'd0, out_valid}, 32'd0);
        expect_result("t2", 32'hC302_0000, 1'b0);

        // Signed zeros, infinities and raw denormal ordering.
        send_beat(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
        expect_result("t3_zero_a", 32'h8000_0000, 1'b0);
        send_beat(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        expect_result("t3_zero_b", 32'h8000_0000, 1'b0);
        send_beat(32'hFF80_0000, 32'hC302_0000, 1'b1, 1'b1);
        expect_result("t3_neg_inf", 32'hFF80_0000, 1'b0);
        send_beat(32'h7F80_0000, 32'h7F7F_FFFF, 1'b1, 1'b1);
        expect_result("t3_pos_inf", 32'h7F7F_FFFF, 1'b0);
        send_beat(32'h8000_0001, 32'h8000_0002, 1'b1, 1'b1);
        expect_result("t3_neg_denorm", 32'h8000_0002, 1'b0);

        // NaN handling, including a canonical-NaN accumulator.
        send_beat(32'h7FC0_0001, 32'h3F80_0000, 1'b1, 1'b1);
        expect_result("t4_one_nan", 32'h3F80_0000, 1'b1);
        send_beat(32'h7FC0_0001, 32'hFFC0_0002, 1'b1, 1'b1);
        expect_result("t4_two_nan", 32'h7FC0_0000, 1'b1);
        send_beat(32'h7FC0_0001, 32'h7FC0_0002, 1'b1, 1'b0);
        send_beat(32'h4000_0000, 32'h4040_0000, 1'b0, 1'b1);
        expect_result("t4_nan_acc", 32'h4000_0000, 1'b1);

        // A new first in ACCUM drops the open group and its sticky NaN.
        send_beat(32'h7FC0_0001, 32'hC200_0000, 1'b1, 1'b0);
        send_beat(32'h4040_0000, 32'h4080_0000, 1'b1, 1'b1);
        expect_result("t4_regroup", 32'h4040_0000, 1'b0);

        // Backpressure: result held, new beat refused until the result drains.
        out_ready = 1'b0;
        send_beat(32'h40A0_0000, 32'h40C0_0000, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        read_data1 = 32'hC000_0000;
        read_data2 = 32'h3F80_0000;
        first      = 1'b1;
        last       = 1'b1;
        in_valid   = 1'b1;
        #1;
        check("t5_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_data", mindata_out, 32'h40A0_0000);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5_drained", {31'd0, out_valid}, 32'd0);
        step();
        check("t5_second_valid", {31'd0, out_valid}, 32'd1);
        check("t5_second_data", mindata_out, 32'hC000_0000);
        step();
        check("t5_second_pulse", {31'd0, out_valid}, 32'd0);

        // Enable low: nothing accepted, nothing produced.
        Fmin_en    = 1'b0;
        read_data1 = 32'h3F80_0000;
        read_data2 = 32'h3F80_0000;
        first      = 1'b1;
        last       = 1'b1;
        in_valid   = 1'b1;
        #1;
        check("t6_en_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_en_no_out", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        Fmin_en  = 1'b1;

        // Reset mid-group discards the open accumulator.
        send_beat(32'hC200_0000, 32'h4000_0000, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data", mindata_out, 32'h0);
        check("t6_rst_nan", {31'd0, nan_flag}, 32'd0);
        send_beat(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
        expect_result("t6_no_first", 32'h3F80_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
